// File: rtl/cursor_pkg.sv
// Shared types and constants for the grid cursor controller.
// Latency: n/a (types, constants and a pure clamp helper only).
// Backpressure: n/a.
package cursor_pkg;

    localparam int IDX_W        = 3;
    localparam int GRID_SIZE_DEF = 5;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        HOLD     = 2'd2
    } state_e;

    // Encoding doubles as the bit position in the synchronized button vector.
    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_e;

    // Step an index by +/-1 and clamp to 0..grid-1. The extra top bit
    // exposes a decrement below zero so it can be clamped instead of wrapping.
    function automatic logic [IDX_W-1:0] step_idx(input logic [IDX_W-1:0] idx,
                                                  input logic             inc,
                                                  input int               grid);
        logic [IDX_W:0] wide;
        logic [IDX_W:0] top;
        top = (IDX_W+1)'(grid - 1);
        if (inc) begin
            wide = {1'b0, idx} + {{IDX_W{1'b0}}, 1'b1};
        end else begin
            wide = {1'b0, idx} - {{IDX_W{1'b0}}, 1'b1};
        end
        if (wide[IDX_W] && !inc) begin
            wide = '0;
        end else if (wide > top) begin
            wide = top;
        end
        return wide[IDX_W-1:0];
    endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer bringing one raw pushbutton into the clk domain.
// Latency: 2 clk edges from input change to sync_o change.
// Backpressure: none; free-running, output always valid.
module btn_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    // First flop may go metastable; second flop gives it a cycle to settle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/cursor_control.sv
// Debounced four-button cursor: one clamped row/column step per accepted press.
// Latency: press sampled at edge 1 commits (and pulses) at edge DEBOUNCE_CYCLES+3.
// Backpressure: none; held buttons never repeat, move_en low freezes and resyncs.
module cursor_control
    import cursor_pkg::*;
#(
    parameter int GRID_SIZE       = GRID_SIZE_DEF,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_left,
    input  logic             btn_right,
    input  logic             move_en,
    input  logic [IDX_W-1:0] i_actual,
    input  logic [IDX_W-1:0] j_actual,
    output logic [IDX_W-1:0] i_next,
    output logic [IDX_W-1:0] j_next,
    output logic             move_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic up_s, down_s, left_s, right_s;
    logic [3:0] btn_s;

    btn_sync u_sync_up    (.clk(clk), .rst(rst), .async_i(btn_up),    .sync_o(up_s));
    btn_sync u_sync_down  (.clk(clk), .rst(rst), .async_i(btn_down),  .sync_o(down_s));
    btn_sync u_sync_left  (.clk(clk), .rst(rst), .async_i(btn_left),  .sync_o(left_s));
    btn_sync u_sync_right (.clk(clk), .rst(rst), .async_i(btn_right), .sync_o(right_s));

    // Bit order matches dir_e so btn_s[dir] selects that direction's button.
    assign btn_s = {right_s, left_s, down_s, up_s};

    state_e           state_q, state_d;
    dir_e             dir_q, dir_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] i_q, i_d, j_q, j_d;
    logic             pulse_q, pulse_d;

    logic one_hot;
    dir_e press_dir;

    // Exactly one button pressed; chords are ignored entirely.
    assign one_hot = (btn_s != 4'd0) && ((btn_s & (btn_s - 4'd1)) == 4'd0);

    // Encode the single pressed button into a direction.
    always_comb begin
        press_dir = UP;
        if (btn_s[DOWN])  press_dir = DOWN;
        if (btn_s[LEFT])  press_dir = LEFT;
        if (btn_s[RIGHT]) press_dir = RIGHT;
    end

    // Next-state, counter, index and pulse logic for the press FSM.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        i_d     = i_q;
        j_d     = j_q;
        pulse_d = 1'b0;

        if (!move_en) begin
            // Game not accepting moves: track the committed position instead.
            state_d = IDLE;
            cnt_d   = '0;
            i_d     = i_actual;
            j_d     = j_actual;
        end else begin
            case (state_q)
                IDLE: begin
                    if (one_hot) begin
                        dir_d   = press_dir;
                        cnt_d   = '0;
                        state_d = DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (!btn_s[dir_q]) begin
                        state_d = IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = HOLD;
                        case (dir_q)
                            UP:      i_d = step_idx(i_q, 1'b0, GRID_SIZE);
                            DOWN:    i_d = step_idx(i_q, 1'b1, GRID_SIZE);
                            LEFT:    j_d = step_idx(j_q, 1'b0, GRID_SIZE);
                            default: j_d = step_idx(j_q, 1'b1, GRID_SIZE);
                        endcase
                        // A clamped step at the grid edge is not a move.
                        pulse_d = (i_d != i_q) || (j_d != j_q);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (btn_s == 4'd0) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State register; reset aborts any press in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            dir_q   <= UP;
            cnt_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            i_q     <= i_d;
            j_q     <= j_d;
            pulse_q <= pulse_d;
        end
    end

    assign i_next     = i_q;
    assign j_next     = j_q;
    assign move_pulse = pulse_q;

endmodule

// File: tb/tb_cursor_control.sv
// Bench for cursor_control at GRID_SIZE=5, DEBOUNCE_CYCLES=4.
// Latency: expects each accepted press to pulse 6 edges after its first sampled edge.
// Backpressure: n/a; pulses are matched against a queue of expected moves.
module tb_cursor_control;

    localparam int DEB = 4;
    localparam logic [3:0] B_UP    = 4'b0001;
    localparam logic [3:0] B_DOWN  = 4'b0010;
    localparam logic [3:0] B_LEFT  = 4'b0100;
    localparam logic [3:0] B_RIGHT = 4'b1000;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_up, btn_down, btn_left, btn_right;
    logic       move_en;
    logic [2:0] i_actual, j_actual;
    logic [2:0] i_next, j_next;
    logic       move_pulse;

    cursor_control #(.GRID_SIZE(5), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .move_en    (move_en),
        .i_actual   (i_actual),
        .j_actual   (j_actual),
        .i_next     (i_next),
        .j_next     (j_next),
        .move_pulse (move_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         edge_no;
        logic [2:0] ei;
        logic [2:0] ej;
    } exp_t;

    typedef struct {
        logic [3:0] btn;
        int         hold;
        logic       pulse;
        logic [2:0] ei;
        logic [2:0] ej;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[13];
    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_err  = 0;

    task automatic set_btn(input logic [3:0] b);
        btn_up    = b[0];
        btn_down  = b[1];
        btn_left  = b[2];
        btn_right = b[3];
    endtask

    // Advance one edge, then check any pulse against the scoreboard.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        cyc++;
        #1;
        if (move_pulse) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_pulse: edge=%0d i_next=%0d j_next=%0d, required no pulse",
                         cyc, i_next, j_next);
            end else begin
                e = sb.pop_front();
                if (cyc != e.edge_no || i_next != e.ei || j_next != e.ej) begin
                    n_err++;
                    $display("FAIL pulse: got edge=%0d i=%0d j=%0d, required edge=%0d i=%0d j=%0d",
                             cyc, i_next, j_next, e.edge_no, e.ei, e.ej);
                end
            end
        end
    endtask

    task automatic check(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    task automatic check_sb(input string name);
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL %s: %0d expected pulse(s) never arrived, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic expect_pulse(input int edge_no, input logic [2:0] ei, input logic [2:0] ej);
        exp_t e;
        e.edge_no = edge_no;
        e.ei      = ei;
        e.ej      = ej;
        sb.push_back(e);
    endtask

    // Hold a button pattern for 'hold' edges, release and let the FSM settle.
    task automatic press(input logic [3:0] b, input int hold, input logic pulse,
                         input logic [2:0] ei, input logic [2:0] ej);
        if (pulse) expect_pulse(cyc + 1 + DEB + 2, ei, ej);
        set_btn(b);
        repeat (hold) tick();
        set_btn(4'b0000);
        repeat (5) tick();
    endtask

    initial begin
        vecs[0]  = '{B_RIGHT,         12, 1'b1, 3'd0, 3'd1}; // clean press
        vecs[1]  = '{B_RIGHT,         12, 1'b1, 3'd0, 3'd2}; // second press
        vecs[2]  = '{B_DOWN,           2, 1'b0, 3'd0, 3'd2}; // bounce
        vecs[3]  = '{B_RIGHT,         12, 1'b1, 3'd0, 3'd3};
        vecs[4]  = '{B_RIGHT,         12, 1'b1, 3'd0, 3'd4};
        vecs[5]  = '{B_RIGHT,         12, 1'b0, 3'd0, 3'd4}; // clamp at right edge
        vecs[6]  = '{B_UP,            12, 1'b0, 3'd0, 3'd4}; // clamp at top edge
        vecs[7]  = '{B_DOWN,          12, 1'b1, 3'd1, 3'd4};
        vecs[8]  = '{B_LEFT,          12, 1'b1, 3'd1, 3'd3};
        vecs[9]  = '{B_UP,            12, 1'b1, 3'd0, 3'd3};
        vecs[10] = '{B_DOWN,           4, 1'b0, 3'd0, 3'd3}; // one cycle short
        vecs[11] = '{B_DOWN,           5, 1'b1, 3'd1, 3'd3}; // just long enough
        vecs[12] = '{B_UP | B_LEFT,   12, 1'b0, 3'd1, 3'd3}; // chord ignored

        rst = 1'b0; move_en = 1'b1; i_actual = 3'd0; j_actual = 3'd0;
        set_btn(4'b0000);
        #1 rst = 1'b1;
        #2;
        check("reset_i_next", i_next, 0);
        check("reset_j_next", j_next, 0);
        check("reset_move_pulse", move_pulse, 0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (2) tick();

        for (int v = 0; v < 13; v++) begin
            press(vecs[v].btn, vecs[v].hold, vecs[v].pulse, vecs[v].ei, vecs[v].ej);
            check_sb($sformatf("vec%0d_pulses", v));
            check($sformatf("vec%0d_i_next", v), i_next, vecs[v].ei);
            check($sformatf("vec%0d_j_next", v), j_next, vecs[v].ej);
        end

        // Left pressed while a right press sits in HOLD: no second move.
        expect_pulse(cyc + 1 + DEB + 2, 3'd1, 3'd4);
        set_btn(B_RIGHT);
        repeat (8) tick();
        set_btn(B_RIGHT | B_LEFT);
        repeat (4) tick();
        set_btn(B_LEFT);
        repeat (6) tick();
        set_btn(4'b0000);
        repeat (5) tick();
        check_sb("hold_left_pulses");
        check("hold_left_i_next", i_next, 1);
        check("hold_left_j_next", j_next, 4);
        press(B_LEFT, 12, 1'b1, 3'd1, 3'd3);
        check_sb("after_hold_left_pulses");
        check("after_hold_left_j_next", j_next, 3);

        // Disabled: indices follow the committed position.
        move_en = 1'b0; i_actual = 3'd3; j_actual = 3'd2;
        tick();
        check("resync_i_next", i_next, 3);
        check("resync_j_next", j_next, 2);
        move_en = 1'b1;
        tick();
        press(B_UP, 12, 1'b1, 3'd2, 3'd2);
        check_sb("resync_up_pulses");
        check("resync_up_i_next", i_next, 2);

        // move_en dropped mid-debounce: no commit.
        i_actual = 3'd2;
        set_btn(B_DOWN);
        repeat (4) tick();
        move_en = 1'b0;
        repeat (8) tick();
        set_btn(4'b0000);
        repeat (3) tick();
        move_en = 1'b1;
        repeat (3) tick();
        check_sb("drop_en_pulses");
        check("drop_en_i_next", i_next, 2);
        check("drop_en_j_next", j_next, 2);

        // Reset in the middle of a debounce, button held through release.
        set_btn(B_DOWN);
        repeat (5) tick();
        #2 rst = 1'b1;
        #1;
        check("async_rst_i_next", i_next, 0);
        check("async_rst_j_next", j_next, 0);
        check("async_rst_move_pulse", move_pulse, 0);
        repeat (2) tick();
        rst = 1'b0;
        expect_pulse(cyc + 7, 3'd1, 3'd0);
        repeat (12) tick();
        set_btn(4'b0000);
        repeat (5) tick();
        check_sb("rst_mid_pulses");
        check("rst_mid_i_next", i_next, 1);
        check("rst_mid_j_next", j_next, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
